// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream drain.
// The optional stream pop counter is enabled with FIFO_RD_CNT_EN (see fifo_stream_reader).
package fifo_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUF_DEPTH = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        cnt_t;

    // Words that will be held once the pending read lands and the current pop leaves.
    function automatic logic [2:0] occupancy(input cnt_t count, input logic inflight, input logic pop);
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream bundled for the stream reader.
// master = reader side, slave = FIFO/sink side.
interface fifo_stream_reader_if #(parameter int unsigned DATA_W = fifo_pkg::DATA_W);

    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  fifo_data_out, fifo_empty, m_ready,
        output fifo_r_en, m_data, m_valid
    );

    modport slave (
        output fifo_data_out, fifo_empty, m_ready,
        input  fifo_r_en, m_data, m_valid
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry shift-style output buffer; entry 0 is always the stream head,
// so m_data comes straight from a flop.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output cnt_t              count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    cnt_t              count_q, count_d;
    logic              valid_q, valid_d;

    // Next buffer contents for every write/pop combination.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({wr_en, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_d  = wr_data;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    ent1_d  = wr_data;
                    count_d = 2'd2;
                end else begin
                    count_d = count_q;
                end
            end
            2'b01: begin
                if (count_q != 2'd0) begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end else begin
                    count_d = count_q;
                end
            end
            2'b11: begin
                // Head leaves while the new word joins the tail; count is unchanged.
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = wr_data;
                end else begin
                    ent0_d = wr_data;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
        valid_d = (count_d != 2'd0);
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign count      = count_q;
    assign head_data  = ent0_q;
    assign head_valid = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream.
// Define FIFO_RD_CNT_EN to add the 32-bit rd_count pop counter output.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    fifo_stream_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [31:0]          rd_count
`endif
);

    logic              inflight_q, inflight_d;
    logic              pop_s;
    logic              fifo_r_en_s;
    logic [2:0]        occ_s;
    cnt_t              count_s;
    logic [DATA_W-1:0] head_data_s;
    logic              head_valid_s;

    assign pop_s = head_valid_s & bus.m_ready;

    // Issue a read only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        occ_s = occupancy(count_s, inflight_q, pop_s);
        if (rst_n && en && !bus.fifo_empty && (occ_s < 3'(BUF_DEPTH))) begin
            fifo_r_en_s = 1'b1;
        end else begin
            fifo_r_en_s = 1'b0;
        end
        inflight_d = fifo_r_en_s;
    end

    // Tracks the read whose data arrives on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (inflight_q),
        .wr_data    (bus.fifo_data_out),
        .pop        (pop_s),
        .count      (count_s),
        .head_data  (head_data_s),
        .head_valid (head_valid_s)
    );

    assign bus.fifo_r_en = fifo_r_en_s;
    assign bus.m_data    = head_data_s;
    assign bus.m_valid   = head_valid_s;

`ifdef FIFO_RD_CNT_EN
    logic [31:0] rd_count_q, rd_count_d;

    // Pop counter, wraps naturally at 2^32.
    always_comb begin
        if (pop_s) begin
            rd_count_d = rd_count_q + 32'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench: a queue-based FIFO model feeds the reader and a scoreboard
// checks stream order, latency, backpressure, en gating and async reset.
module tb_fifo_stream_reader;

    logic clk;
    logic rst_n;
    logic en;

    fifo_stream_reader_if bus ();

`ifdef FIFO_RD_CNT_EN
    logic [31:0] rd_count;
`endif

    fifo_stream_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];
    logic [7:0] eq[$];
    int reads = 0;
    int pops  = 0;

    logic       r_en_e  = 1'b0;
    logic       pop_e   = 1'b0;
    logic [7:0] pdata_e = 8'd0;
    logic       stall_e = 1'b0;
    logic [7:0] held_e  = 8'd0;

    // What the DUT saw on each rising edge.
    always @(posedge clk) begin
        r_en_e  <= bus.fifo_r_en;
        pop_e   <= bus.m_valid & bus.m_ready;
        pdata_e <= bus.m_data;
        stall_e <= bus.m_valid & ~bus.m_ready;
        held_e  <= bus.m_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        eq.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: update FIFO model and scoreboard, then check invariants.
    task automatic step();
        @(negedge clk);
        if (r_en_e) begin
            if (fq.size() == 0) check("underflow", 32'd1, 32'd0);
            else bus.fifo_data_out = fq.pop_front();
            reads++;
        end
        bus.fifo_empty = (fq.size() == 0);
        if (pop_e) begin
            pops++;
            if (eq.size() == 0) check("pop_extra", 32'd1, 32'd0);
            else check("pop_data", {24'd0, pdata_e}, {24'd0, eq.pop_front()});
        end
        #1;
        check("rd_while_empty", {31'd0, bus.fifo_r_en & bus.fifo_empty}, 32'd0);
        check("occupancy_le2", {31'd0, (reads - pops) <= 2}, 32'd1);
        if (stall_e) begin
            check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
            check("stall_data", {24'd0, bus.m_data}, {24'd0, held_e});
        end
`ifdef FIFO_RD_CNT_EN
        check("rd_count", rd_count, 32'(pops));
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((eq.size() != 0 || bus.m_valid) && n < 300) begin
            step();
            n++;
        end
        check(tag, {31'd0, n < 300}, 32'd1);
    endtask

    initial begin
        int r0;
        int p0;
        int pushed;
        int guard;
        rst_n = 1'b0;
        en = 1'b1;
        bus.m_ready = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_data_out = 8'd0;

        // Reset held with words waiting in the FIFO.
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
            check("rst_valid", {31'd0, bus.m_valid}, 32'd0);
            check("rst_data", {24'd0, bus.m_data}, 32'd0);
        end
        rst_n = 1'b1;
        drain("drain_rst");

        // Streaming 0x01..0x10 with continuous ready.
        en = 1'b0;
        step();
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        en = 1'b1;
        step();
        check("lat_e0_valid", {31'd0, bus.m_valid}, 32'd0);
        step();
        check("lat_e1_valid", {31'd0, bus.m_valid}, 32'd1);
        check("lat_e1_data", {24'd0, bus.m_data}, 32'h01);
        for (int i = 0; i < 16; i++) begin
            step();
            check("stream_gap", {31'd0, pop_e}, 32'd1);
        end
        check("stream_end", {31'd0, bus.m_valid}, 32'd0);

        // Backpressure: 8 words, sink stalled for 10 cycles.
        en = 1'b0;
        bus.m_ready = 1'b0;
        step();
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        r0 = reads;
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("bp_reads", 32'(reads - r0), 32'd2);
        check("bp_valid", {31'd0, bus.m_valid}, 32'd1);
        check("bp_data", {24'd0, bus.m_data}, 32'h30);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("bp_gap", {31'd0, pop_e}, 32'd1);
        end
        drain("drain_bp");

        // en dropped with one word buffered and one in flight.
        en = 1'b0;
        bus.m_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        r0 = reads;
        p0 = pops;
        en = 1'b1;
        step();
        step();
        en = 1'b0;
        check("eg_reads", 32'(reads - r0), 32'd2);
        check("eg_valid", {31'd0, bus.m_valid}, 32'd1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("eg_hold_reads", 32'(reads - r0), 32'd2);
        check("eg_delivered", 32'(pops - p0), 32'd2);
        en = 1'b1;
        drain("drain_eg");
        check("eg_fifo_empty", 32'(fq.size()), 32'd0);

        // Random ready/en with sporadic FIFO writes.
        p0 = pops;
        pushed = 0;
        guard = 0;
        while ((pushed < 64 || eq.size() != 0 || bus.m_valid) && guard < 3000) begin
            if (pushed < 64 && ($urandom % 2) == 0) begin
                push_word(8'($urandom));
                pushed++;
            end
            bus.m_ready = ($urandom % 2) == 0;
            en = ($urandom % 8) != 0;
            step();
            guard++;
        end
        check("rnd_timeout", {31'd0, guard < 3000}, 32'd1);
        check("rnd_count", 32'(pops - p0), 32'd64);
        check("rnd_left", 32'(eq.size()), 32'd0);

        // Asynchronous reset in the middle of a burst.
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'h70 + 8'(i));
        step(); step(); step();
        check("ar_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, bus.m_valid}, 32'd0);
        check("ar_data", {24'd0, bus.m_data}, 32'd0);
        check("ar_r_en", {31'd0, bus.fifo_r_en}, 32'd0);
        fq.delete();
        eq.delete();
        reads = 0;
        pops = 0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data_out = 8'd0;
        step();
        rst_n = 1'b1;
        step();
        check("ar_after_valid", {31'd0, bus.m_valid}, 32'd0);

        // Twenty pops after reset; rd_count is compared every cycle when present.
        for (int i = 0; i < 20; i++) push_word(8'($urandom));
        drain("drain_cnt");
        check("cnt_pops", 32'(pops), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
